// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the iterative inverse cipher.
// Contents: SBOX / INV_SBOX tables, RCON[1:10], GF(2^8) multiply helpers,
// FSM state enum, column-major byte position helper, and the forward and
// inverse single-round key schedule steps.
// State/key byte order: bits [127:120] = byte 0, byte index = row + 4*col.
package aes_pkg;

   typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_ADDK, S_DEC, S_DONE} state_t;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   // Table byte b sits at bit 2047-8*b, i.e. {~b, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[{~b, 3'b111} -: 8];
   endfunction

   // Out-of-range round numbers (0, 11+) yield 0; those results are discarded.
   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] r;
      r = 8'h00;
      if (i >= 4'd1 && i <= 4'd10) r = RCON[i];
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   // MSB position of state byte (row r, column c).
   function automatic int bpos(input int r, input int c);
      return 127 - 8 * (r + 4 * c);
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   // K_{i-1} -> K_i
   function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0]  ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // K_i -> K_{i-1}; rc is the rcon used to produce K_i.
   function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0]  ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// st_in      : round input state
// rk         : round key for this round
// last_round : 1 bypasses InvMixColumns (final round)
// st_out     : InvMixColumns(InvSubBytes(InvShiftRows(st_in)) ^ rk)
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] st_in,
   input  logic [127:0] rk,
   input  logic         last_round,
   output logic [127:0] st_out
);
   logic [127:0] sb_st, ak_st, mc_st;

   // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
   always_comb begin
      sb_st = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sb_st[bpos(r, c) -: 8] = inv_sbox(st_in[bpos(r, (c - r + 4) % 4) -: 8]);
   end

   assign ak_st = sb_st ^ rk;

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ak_st[127 - 32*c -: 8];
      assign a1 = ak_st[119 - 32*c -: 8];
      assign a2 = ak_st[111 - 32*c -: 8];
      assign a3 = ak_st[103 - 32*c -: 8];
      assign mc_st[127 - 32*c -: 32] = {
         mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
         mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
         mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
         mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
   end

   assign st_out = last_round ? ak_st : mc_st;

endmodule

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Forward key expansion reaches K10, then the schedule is unwound one key
// per cycle alongside the inverse rounds. Optional single-entry cache of
// the last key and its K10 skips expansion on a repeated key.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready high only in IDLE)
//   key, in              cipher key and ciphertext (bits [127:120] = byte 0)
//   out_valid/out_ready  output handshake
//   out                  plaintext, updated only on entry to DONE
module aes128_dec_iter
   import aes_pkg::*;
#(
   parameter int KEY_CACHE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [127:0] in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out
);
   state_t       state, state_nxt;
   logic [3:0]   rnd;
   logic [127:0] rk, st, ct, key_r;
   logic [127:0] cache_key, cache_k10;
   logic         cache_vld, hit;
   logic [127:0] rk_fwd, rk_inv, round_out;
   logic [7:0]   rc_inv;

   assign in_ready = (state == S_IDLE);
   assign hit      = (KEY_CACHE != 0) && cache_vld && (key == cache_key);
   assign rk_fwd   = fwd_step(rk, rcon(rnd));
   // ADDK unwinds K10 -> K9; rnd is not meaningful there.
   assign rc_inv   = (state == S_ADDK) ? RCON[10] : rcon(rnd);
   assign rk_inv   = inv_step(rk, rc_inv);

   aes_inv_round u_round (
      .st_in      (st),
      .rk         (rk),
      .last_round (rnd == 4'd0),
      .st_out     (round_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (in_valid) state_nxt = hit ? S_ADDK : S_KEYEXP;
         S_KEYEXP: if (rnd == 4'd10) state_nxt = S_ADDK;
         S_ADDK:   state_nxt = S_DEC;
         S_DEC:    if (rnd == 4'd0) state_nxt = S_DONE;
         S_DONE:   if (out_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rnd       <= '0;
         rk        <= '0;
         st        <= '0;
         ct        <= '0;
         key_r     <= '0;
         cache_key <= '0;
         cache_k10 <= '0;
         cache_vld <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (in_valid) begin
               ct    <= in;
               key_r <= key;
               if (hit) begin
                  rk <= cache_k10;
               end else begin
                  rk  <= key;
                  rnd <= 4'd1;
               end
            end
            S_KEYEXP: begin
               rk  <= rk_fwd;
               rnd <= rnd + 4'd1;
               if (rnd == 4'd10 && KEY_CACHE != 0) begin
                  cache_k10 <= rk_fwd;
                  cache_key <= key_r;
                  cache_vld <= 1'b1;
               end
            end
            S_ADDK: begin
               st  <= ct ^ rk;
               rk  <= rk_inv;
               rnd <= 4'd9;
            end
            S_DEC: begin
               st <= round_out;
               rk <= rk_inv;
               if (rnd == 4'd0) begin
                  out       <= round_out;
                  out_valid <= 1'b1;
               end else begin
                  rnd <= rnd - 4'd1;
               end
            end
            S_DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Self-checking bench for aes128_dec_iter: FIPS-197 vectors, cache hit/miss
// latency, backpressure, mid-operation reset and randomized round trips
// through a reference AES encryptor built from first principles.
module tb_aes128_dec_iter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid, out_ready, sel;
   logic [127:0] key, din;
   logic         c_in_ready, c_out_valid, n_in_ready, n_out_valid;
   logic [127:0] c_out, n_out;
   logic         o_in_ready, o_out_valid;
   logic [127:0] o_out;

   int checks = 0;
   int failures = 0;
   logic [7:0]   sb [256];
   logic         cvld_m;
   logic [127:0] ckey_m;

   localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

   aes128_dec_iter #(.KEY_CACHE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(c_in_ready),
      .key(key), .in(din), .out_valid(c_out_valid), .out_ready(out_ready & ~sel), .out(c_out));

   aes128_dec_iter #(.KEY_CACHE(0)) dut_nc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(n_in_ready),
      .key(key), .in(din), .out_valid(n_out_valid), .out_ready(out_ready & sel), .out(n_out));

   assign o_in_ready  = sel ? n_in_ready  : c_in_ready;
   assign o_out_valid = sel ? n_out_valid : c_out_valid;
   assign o_out       = sel ? n_out       : c_out;

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from multiplicative inverse plus affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc, s [16], t [16], a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
         if (r < 10)
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
               s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
            end
         for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31 - 8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Starts and ends at a negedge with the selected DUT idle.
   task automatic run_txn(input logic [127:0] k, input logic [127:0] c, input logic [127:0] pt,
                          input int lat, input int gap, input int hold, input bit bp,
                          input bit rnd_ordy, input string tag);
      int n;
      for (int i = 0; i < gap; i++) begin
         in_valid = 1'b0; key = r128(); din = r128(); tick();
      end
      chk({tag, " in_ready idle"}, 128'(o_in_ready), 128'(1));
      in_valid = 1'b1; key = k; din = c;
      tick();
      in_valid = 1'b0; key = r128(); din = r128();
      chk({tag, " in_ready busy"}, 128'(o_in_ready), 128'(0));
      n = 0;
      while (!o_out_valid && n < 60) begin
         out_ready = rnd_ordy ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         n++;
      end
      out_ready = 1'b0;
      chk({tag, " latency"}, 128'(n), 128'(lat));
      chk({tag, " out"}, o_out, pt);
      for (int i = 0; i < hold; i++) begin
         in_valid = bp; key = r128(); din = r128();
         tick();
         if (bp) begin
            chk({tag, " bp out_valid"}, 128'(o_out_valid), 128'(1));
            chk({tag, " bp in_ready"}, 128'(o_in_ready), 128'(0));
            chk({tag, " bp out"}, o_out, pt);
         end
      end
      in_valid = 1'b0;
      if (hold > 0) chk({tag, " out after hold"}, o_out, pt);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " out_valid drop"}, 128'(o_out_valid), 128'(0));
      chk({tag, " in_ready back"}, 128'(o_in_ready), 128'(1));
      chk({tag, " out holds"}, o_out, pt);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [127:0] k, pt, prev_k;
      int lat;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
      key = '0; din = '0;
      build_sbox();
      @(negedge clk);
      tick(); tick();
      chk("reset in_ready", 128'(o_in_ready), 128'(1));
      chk("reset out_valid", 128'(o_out_valid), 128'(0));
      chk("reset out", o_out, 128'(0));
      rst_n = 1'b1;
      tick();

      run_txn(C1_K, C1_CT, C1_PT, 21, 0, 0, 1'b0, 1'b0, "c1 miss");
      run_txn(B_K, B_CT, B_PT, 21, 0, 0, 1'b0, 1'b0, "appb miss");
      run_txn(B_K, B_CT, B_PT, 11, 0, 0, 1'b0, 1'b0, "appb hit");
      run_txn(B_K, B_CT, B_PT, 11, 0, 5, 1'b1, 1'b0, "backpressure");
      run_txn(C1_K, C1_CT, C1_PT, 21, 0, 0, 1'b0, 1'b0, "c1 refill");

      // Cache hit on C.1, then reset while DEC is at rnd=4.
      in_valid = 1'b1; key = C1_K; din = C1_CT;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midreset out_valid", 128'(o_out_valid), 128'(0));
      chk("midreset in_ready", 128'(o_in_ready), 128'(1));
      chk("midreset out", o_out, 128'(0));
      repeat (25) tick();
      chk("midreset no output", 128'(o_out_valid), 128'(0));
      run_txn(C1_K, C1_CT, C1_PT, 21, 0, 0, 1'b0, 1'b0, "c1 after reset");

      sel = 1'b1;
      run_txn(B_K, B_CT, B_PT, 21, 0, 0, 1'b0, 1'b0, "nocache first");
      run_txn(B_K, B_CT, B_PT, 21, 0, 0, 1'b0, 1'b0, "nocache repeat");
      sel = 1'b0;

      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      cvld_m = 1'b0; ckey_m = '0; prev_k = r128();
      for (int i = 0; i < 1000; i++) begin
         k  = ($urandom_range(0, 3) == 0) ? prev_k : r128();
         pt = r128();
         lat = (cvld_m && k == ckey_m) ? 11 : 21;
         if (lat == 21) begin
            cvld_m = 1'b1;
            ckey_m = k;
         end
         run_txn(k, enc(k, pt), pt, lat, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'b0, 1'b1, "random");
         prev_k = k;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
